// File: rtl/ga_seq_if.sv
// Signal bundle between the GA sequencer and its surroundings: the start request and
// fitness results flow in, stage enables and run status flow out.
interface ga_seq_if #(
    parameter int CHROM_W = 8,
    parameter int FIT_W   = 27,
    parameter int GEN_W   = 7
);
    // host and fitness stage towards the sequencer
    logic                    start;
    logic                    fit_valid;
    logic [CHROM_W-1:0]      fit_chrom1;
    logic [CHROM_W-1:0]      fit_chrom2;
    logic signed [FIT_W-1:0] fit_val1;
    logic signed [FIT_W-1:0] fit_val2;

    // sequencer towards the datapath and host
    logic                    src_sel;
    logic                    ff_enable;
    logic                    sel_enable;
    logic                    sel_slot;
    logic                    xover_enable;
    logic                    buf_wenable;
    logic                    buf_renable;
    logic                    busy;
    logic                    done;
    logic [GEN_W-1:0]        generation;
    logic [CHROM_W-1:0]      best;
    logic signed [FIT_W-1:0] best_fit;

    modport master (
        output start, fit_valid, fit_chrom1, fit_chrom2, fit_val1, fit_val2,
        input  src_sel, ff_enable, sel_enable, sel_slot, xover_enable,
               buf_wenable, buf_renable, busy, done, generation, best, best_fit
    );

    modport slave (
        input  start, fit_valid, fit_chrom1, fit_chrom2, fit_val1, fit_val2,
        output src_sel, ff_enable, sel_enable, sel_slot, xover_enable,
               buf_wenable, buf_renable, busy, done, generation, best, best_fit
    );
endinterface

// File: rtl/ga_seq_ctrl.sv
// GA sequencer: schedules the RNG -> FIT -> SEL -> XOVER -> MUT -> BUFFER datapath
// through fill, initial population, steady-state generations and drain, counts
// generations and keeps the best-of-run chromosome.
module ga_seq_ctrl #(
    parameter int                      POP_SIZE   = 16,
    parameter int                      CHROM_W    = 8,
    parameter int                      FIT_W      = 27,
    parameter int                      MAX_GEN    = 64,
    parameter int                      TARGET_EN  = 0,
    parameter logic signed [FIT_W-1:0] TARGET_FIT = '0,
    parameter int                      PIPE_DEPTH = 4,
    parameter int                      XM_LAT     = 2
) (
    input  logic    clk,
    input  logic    reset,
    ga_seq_if.slave bus
);
    localparam int HALF      = POP_SIZE / 2;
    localparam int PAIR_W    = $clog2(HALF);
    localparam int DRAIN_LEN = PIPE_DEPTH + XM_LAT;
    localparam int CNT_W     = $clog2(DRAIN_LEN + 1);
    localparam int GEN_W     = $clog2(MAX_GEN + 1);

    localparam logic [PAIR_W-1:0]       PAIR_LAST  = PAIR_W'(HALF - 1);
    localparam logic [CNT_W-1:0]        FILL_LAST  = CNT_W'(PIPE_DEPTH - 1);
    localparam logic [CNT_W-1:0]        DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);
    localparam logic [GEN_W-1:0]        GEN_MAX    = GEN_W'(MAX_GEN);
    localparam logic signed [FIT_W-1:0] FIT_MIN    = {1'b1, {(FIT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_INIT,
        S_STEADY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;        // fill / drain cycle counter
    logic [PAIR_W-1:0]       pair_reg, pair_next;      // pairs issued in this generation
    logic [GEN_W-1:0]        gen_reg, gen_next;
    logic [GEN_W-1:0]        gen_inc;
    logic [CHROM_W-1:0]      best_reg, best_next;
    logic signed [FIT_W-1:0] best_fit_reg, best_fit_next;
    logic                    slot_reg;
    logic [XM_LAT-1:0]       xm_pipe_reg;

    logic                    start_ok;
    logic                    early_stop;
    logic                    cand_is_2;
    logic signed [FIT_W-1:0] cand_fit;
    logic [CHROM_W-1:0]      cand_chrom;

    logic ff_en, sel_en, xover_en, ren, src, busy_o, done_o;

    // start is only honoured when no run is in flight
    assign start_ok = bus.start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // Best-of-run candidate: larger of the two scores, val1 wins a tie; strict improvement only
    always_comb begin
        cand_is_2     = bus.fit_val2 > bus.fit_val1;
        cand_fit      = cand_is_2 ? bus.fit_val2 : bus.fit_val1;
        cand_chrom    = cand_is_2 ? bus.fit_chrom2 : bus.fit_chrom1;
        best_next     = best_reg;
        best_fit_next = best_fit_reg;
        if (start_ok) begin
            best_next     = '0;
            best_fit_next = FIT_MIN;
        end else if (bus.fit_valid && (state_reg != S_DONE) && (cand_fit > best_fit_reg)) begin
            best_next     = cand_chrom;
            best_fit_next = cand_fit;
        end
    end

    // Early stop looks at the best value being written this cycle, so a qualifying
    // score moves the FSM into DRAIN on the very next cycle.
    assign early_stop = (TARGET_EN != 0) && (best_fit_next >= TARGET_FIT);

    // Saturating generation increment used at every pair-counter wrap
    assign gen_inc = (gen_reg < GEN_MAX) ? gen_reg + 1'b1 : gen_reg;

    // Next-state logic and Moore decode of the stage controls
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pair_next  = pair_reg;
        gen_next   = gen_reg;
        ff_en      = 1'b0;
        sel_en     = 1'b0;
        ren        = 1'b0;
        src        = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                done_o = (state_reg == S_DONE);
                if (start_ok) begin
                    state_next = S_FILL;
                    cnt_next   = '0;
                    pair_next  = '0;
                    gen_next   = '0;
                end
            end

            S_FILL: begin
                ff_en  = 1'b1;
                busy_o = 1'b1;
                sel_en = (cnt_reg == FILL_LAST);
                if (cnt_reg == FILL_LAST) begin
                    state_next = S_INIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (early_stop) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end
            end

            S_INIT, S_STEADY: begin
                ff_en    = 1'b1;
                sel_en   = 1'b1;
                busy_o   = 1'b1;
                ren      = (state_reg == S_STEADY);
                src      = (state_reg == S_STEADY);
                cnt_next = '0;
                if (pair_reg == PAIR_LAST) begin
                    pair_next  = '0;
                    gen_next   = gen_inc;
                    state_next = (gen_inc == GEN_MAX) ? S_DRAIN : S_STEADY;
                end else begin
                    pair_next = pair_reg + 1'b1;
                end
                if (early_stop) begin
                    state_next = S_DRAIN;
                end
            end

            S_DRAIN: begin
                ff_en  = 1'b1;
                sel_en = 1'b1;
                busy_o = 1'b1;
                src    = 1'b1;
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Crossover fires once both parent slots hold fresh winners
    assign xover_en = sel_en & slot_reg;

    // FSM, counters and best-of-run registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            pair_reg     <= '0;
            gen_reg      <= '0;
            best_reg     <= '0;
            best_fit_reg <= FIT_MIN;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pair_reg     <= pair_next;
            gen_reg      <= gen_next;
            best_reg     <= best_next;
            best_fit_reg <= best_fit_next;
        end
    end

    // Parent slot alternates 0,1,0,... for as long as selection is enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg <= 1'b0;
        end else begin
            slot_reg <= sel_en ? ~slot_reg : 1'b0;
        end
    end

    // Delay line matching the crossover + mutation latency to the buffer write
    always_ff @(posedge clk) begin
        if (reset) begin
            xm_pipe_reg <= '0;
        end else begin
            xm_pipe_reg[0] <= xover_en;
            for (int i = 1; i < XM_LAT; i++) begin
                xm_pipe_reg[i] <= xm_pipe_reg[i-1];
            end
        end
    end

    assign bus.ff_enable    = ff_en;
    assign bus.sel_enable   = sel_en;
    assign bus.sel_slot     = slot_reg;
    assign bus.xover_enable = xover_en;
    assign bus.buf_wenable  = xm_pipe_reg[XM_LAT-1];
    assign bus.buf_renable  = ren;
    assign bus.src_sel      = src;
    assign bus.busy         = busy_o;
    assign bus.done         = done_o;
    assign bus.generation   = gen_reg;
    assign bus.best         = best_reg;
    assign bus.best_fit     = best_fit_reg;
endmodule

// File: tb/tb_ga_seq_ctrl.sv
// Bench for ga_seq_ctrl: randomized fitness traffic against a cycle-schedule and
// best-of-run reference model derived from the phase lengths of a run.
module tb_ga_seq_ctrl;
    localparam int POP_SIZE   = 16;
    localparam int CHROM_W    = 8;
    localparam int FIT_W      = 27;
    localparam int MAX_GEN    = 3;
    localparam int TARGET_EN  = 1;
    localparam int TFIT       = 100;
    localparam int PD         = 4;
    localparam int XM         = 2;
    localparam int H          = POP_SIZE / 2;
    localparam int GEN_W      = $clog2(MAX_GEN + 1);
    localparam int DRAIN_NOM  = PD + H + 1 + (MAX_GEN - 1) * H;
    localparam logic signed [FIT_W-1:0] FIT_MIN = {1'b1, {(FIT_W-1){1'b0}}};

    localparam int P_IDLE = 0, P_FILL = 1, P_INIT = 2, P_STEADY = 3, P_DRAIN = 4, P_DONE = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ga_seq_if #(.CHROM_W(CHROM_W), .FIT_W(FIT_W), .GEN_W(GEN_W)) bus ();

    ga_seq_ctrl #(
        .POP_SIZE(POP_SIZE), .CHROM_W(CHROM_W), .FIT_W(FIT_W), .MAX_GEN(MAX_GEN),
        .TARGET_EN(TARGET_EN), .TARGET_FIT(FIT_W'(TFIT)), .PIPE_DEPTH(PD), .XM_LAT(XM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state: cycles since accepted start (0 = idle), DRAIN entry cycle, best
    int                      t = 0;
    int                      drain_start = DRAIN_NOM;
    logic [CHROM_W-1:0]      m_best = '0;
    logic signed [FIT_W-1:0] m_best_fit = FIT_MIN;

    function automatic int phase_of(int tt);
        if (tt <= 0)                        return P_IDLE;
        if (tt >= drain_start + PD + XM)    return P_DONE;
        if (tt >= drain_start)              return P_DRAIN;
        if (tt <= PD)                       return P_FILL;
        if (tt <= PD + H)                   return P_INIT;
        return P_STEADY;
    endfunction

    function automatic bit exp_sel(int tt);
        int ph;
        ph = phase_of(tt);
        return (ph == P_INIT) || (ph == P_STEADY) || (ph == P_DRAIN) || (ph == P_FILL && tt == PD);
    endfunction

    function automatic bit exp_slot(int tt);
        if (!exp_sel(tt)) return 1'b0;
        return ((tt - PD) % 2) == 1;
    endfunction

    function automatic bit exp_xover(int tt);
        return exp_sel(tt) && exp_slot(tt);
    endfunction

    function automatic int exp_gen(int tt);
        int g;
        int te;
        if (tt <= PD + H) return 0;
        te = (tt < drain_start) ? tt : drain_start;
        g = 1 + (te - (PD + H + 1)) / H;
        if (g > MAX_GEN) g = MAX_GEN;
        return g;
    endfunction

    // {ff, sel, xover, wen, ren, busy, done}
    function automatic logic [6:0] exp_vec(int tt);
        int ph;
        bit run;
        ph  = phase_of(tt);
        run = (ph == P_FILL) || (ph == P_INIT) || (ph == P_STEADY) || (ph == P_DRAIN);
        return {run, exp_sel(tt), exp_xover(tt), exp_xover(tt - XM), ph == P_STEADY, run, ph == P_DONE};
    endfunction

    function automatic logic [6:0] ctrl_vec();
        return {bus.ff_enable, bus.sel_enable, bus.xover_enable, bus.buf_wenable,
                bus.buf_renable, bus.busy, bus.done};
    endfunction

    // advance one clock and update the model from the inputs that edge sampled
    task automatic tick();
        int ph;
        logic signed [FIT_W-1:0] cf;
        logic [CHROM_W-1:0]      cc;
        ph = phase_of(t);
        @(posedge clk);
        #1;
        if (reset) begin
            t = 0;
            drain_start = DRAIN_NOM;
            m_best = '0;
            m_best_fit = FIT_MIN;
        end else if (bus.start && (ph == P_IDLE || ph == P_DONE)) begin
            t = 1;
            drain_start = DRAIN_NOM;
            m_best = '0;
            m_best_fit = FIT_MIN;
        end else begin
            if (bus.fit_valid && ph != P_DONE) begin
                if (bus.fit_val2 > bus.fit_val1) begin cf = bus.fit_val2; cc = bus.fit_chrom2; end
                else                             begin cf = bus.fit_val1; cc = bus.fit_chrom1; end
                if (cf > m_best_fit) begin
                    m_best = cc;
                    m_best_fit = cf;
                end
            end
            if (TARGET_EN != 0 && m_best_fit >= FIT_W'(TFIT) &&
                (ph == P_FILL || ph == P_INIT || ph == P_STEADY) && t + 1 < drain_start)
                drain_start = t + 1;
            if (t > 0) t++;
        end
    endtask

    // random fitness traffic, always below the early-stop threshold
    task automatic drive_fit(input bit en);
        int v1, v2;
        v1 = int'($urandom_range(1099)) - 1000;
        v2 = int'($urandom_range(1099)) - 1000;
        if ($urandom_range(7) == 0) v2 = v1;
        bus.fit_valid  = en && ($urandom_range(3) != 0);
        bus.fit_chrom1 = CHROM_W'($urandom);
        bus.fit_chrom2 = CHROM_W'($urandom);
        bus.fit_val1   = FIT_W'(v1);
        bus.fit_val2   = FIT_W'(v2);
    endtask

    task automatic set_fit(input bit v, input int c1, input int c2, input int f1, input int f2);
        bus.fit_valid  = v;
        bus.fit_chrom1 = CHROM_W'(c1);
        bus.fit_chrom2 = CHROM_W'(c2);
        bus.fit_val1   = FIT_W'(f1);
        bus.fit_val2   = FIT_W'(f2);
    endtask

    task automatic pulse_start();
        set_fit(1'b0, 0, 0, 0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        set_fit(1'b0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (ctrl_vec() !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", ctrl_vec(), 7'b0);
        end
        checks++;
        if ({bus.src_sel, bus.sel_slot} !== 2'b00) begin
            errors++;
            $display("FAIL reset_src_slot got %b want 00", {bus.src_sel, bus.sel_slot});
        end
        checks++;
        if (bus.generation !== GEN_W'(0) || bus.best !== CHROM_W'(0)) begin
            errors++;
            $display("FAIL reset_gen_best got gen=%0d best=%h want 0/00", bus.generation, bus.best);
        end
        checks++;
        if (bus.best_fit !== FIT_MIN) begin
            errors++;
            $display("FAIL reset_best_fit got %0d want %0d", bus.best_fit, FIT_MIN);
        end
        $display("reset: outputs idle, best_fit=%0d", bus.best_fit);
    endtask

    task automatic test_best();
        pulse_start();
        set_fit(1'b1, 'h11, 'h22, -5, 7);
        tick();
        checks++;
        if (bus.best !== 8'h22 || bus.best_fit !== FIT_W'(7)) begin
            errors++;
            $display("FAIL best_pick2 got %h/%0d want 22/7", bus.best, bus.best_fit);
        end
        set_fit(1'b1, 'h33, 'h44, 7, 7);
        tick();
        checks++;
        if (bus.best !== 8'h22 || bus.best_fit !== FIT_W'(7)) begin
            errors++;
            $display("FAIL best_equal_keep got %h/%0d want 22/7", bus.best, bus.best_fit);
        end
        set_fit(1'b1, 'h55, 'h66, 9, 9);
        tick();
        checks++;
        if (bus.best !== 8'h55 || bus.best_fit !== FIT_W'(9)) begin
            errors++;
            $display("FAIL best_tie_val1 got %h/%0d want 55/9", bus.best, bus.best_fit);
        end
        set_fit(1'b1, 'h77, 'h88, -3, 9);
        tick();
        checks++;
        if (bus.best !== m_best || bus.best_fit !== m_best_fit || bus.best !== 8'h55) begin
            errors++;
            $display("FAIL best_strict got %h/%0d want 55/9", bus.best, bus.best_fit);
        end
        $display("best: best=%h best_fit=%0d", bus.best, bus.best_fit);
        do_reset();
    endtask

    task automatic test_schedule();
        int last;
        pulse_start();
        last = DRAIN_NOM + PD + XM + 3;
        for (int k = 0; k < last; k++) begin
            checks++;
            if (ctrl_vec() !== exp_vec(t)) begin
                errors++;
                $display("FAIL sched_ctrl t=%0d got %b want %b (ff sel xov wen ren busy done)", t, ctrl_vec(), exp_vec(t));
            end
            if (phase_of(t) == P_FILL || phase_of(t) == P_INIT || phase_of(t) == P_STEADY) begin
                checks++;
                if (bus.src_sel !== (phase_of(t) == P_STEADY)) begin
                    errors++;
                    $display("FAIL sched_src t=%0d got %b want %b", t, bus.src_sel, phase_of(t) == P_STEADY);
                end
            end
            if (exp_sel(t)) begin
                checks++;
                if (bus.sel_slot !== exp_slot(t)) begin
                    errors++;
                    $display("FAIL sched_slot t=%0d got %b want %b", t, bus.sel_slot, exp_slot(t));
                end
            end
            checks++;
            if (bus.generation !== GEN_W'(exp_gen(t))) begin
                errors++;
                $display("FAIL sched_gen t=%0d got %0d want %0d", t, bus.generation, exp_gen(t));
            end
            checks++;
            if (bus.best !== m_best || bus.best_fit !== m_best_fit) begin
                errors++;
                $display("FAIL sched_best t=%0d got %h/%0d want %h/%0d", t, bus.best, bus.best_fit, m_best, m_best_fit);
            end
            drive_fit(phase_of(t) != P_DONE);
            tick();
        end
        set_fit(1'b0, 0, 0, 0, 0);
        checks++;
        if ({bus.done, bus.busy} !== 2'b10 || bus.generation !== GEN_W'(MAX_GEN)) begin
            errors++;
            $display("FAIL sched_end got done=%b busy=%b gen=%0d want 1/0/%0d", bus.done, bus.busy, bus.generation, MAX_GEN);
        end
        $display("schedule: done=%b generation=%0d best=%h best_fit=%0d", bus.done, bus.generation, bus.best, bus.best_fit);
    endtask

    task automatic test_back_to_back();
        int last;
        pulse_start();
        checks++;
        if (bus.generation !== GEN_W'(0) || bus.best_fit !== FIT_MIN || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart got gen=%0d fit=%0d busy=%b want 0/%0d/1", bus.generation, bus.best_fit, bus.busy, FIT_MIN);
        end
        last = DRAIN_NOM + PD + XM + 3;
        while (t < last) begin
            drive_fit(phase_of(t) != P_DONE);
            tick();
            checks++;
            if (ctrl_vec() !== exp_vec(t) || bus.generation !== GEN_W'(exp_gen(t))) begin
                errors++;
                $display("FAIL b2b_cycle t=%0d got %b gen=%0d want %b gen=%0d", t, ctrl_vec(), bus.generation, exp_vec(t), exp_gen(t));
            end
            checks++;
            if (bus.best_fit !== m_best_fit) begin
                errors++;
                $display("FAIL b2b_best t=%0d got %0d want %0d", t, bus.best_fit, m_best_fit);
            end
        end
        set_fit(1'b0, 0, 0, 0, 0);
        $display("back_to_back: done=%b generation=%0d best_fit=%0d", bus.done, bus.generation, bus.best_fit);
    endtask

    task automatic test_target_stop();
        int hit_t;
        hit_t = PD + H + 1 + H + 3;
        pulse_start();
        while (t < hit_t + PD + XM + 4) begin
            if (t == hit_t) set_fit(1'b1, 'h5a, 'ha5, int'($urandom_range(99)), TFIT);
            else            drive_fit(phase_of(t) != P_DONE);
            tick();
            checks++;
            if (ctrl_vec() !== exp_vec(t) || bus.generation !== GEN_W'(exp_gen(t))) begin
                errors++;
                $display("FAIL target_cycle t=%0d got %b gen=%0d want %b gen=%0d", t, ctrl_vec(), bus.generation, exp_vec(t), exp_gen(t));
            end
            if (t == hit_t + 1) begin
                checks++;
                if ({bus.buf_renable, bus.busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL target_drain_entry got ren=%b busy=%b want 0/1", bus.buf_renable, bus.busy);
                end
            end
        end
        set_fit(1'b0, 0, 0, 0, 0);
        checks++;
        if (bus.done !== 1'b1 || bus.generation !== GEN_W'(2) || bus.best !== 8'ha5 || bus.best_fit !== FIT_W'(TFIT)) begin
            errors++;
            $display("FAIL target_end got done=%b gen=%0d best=%h/%0d want 1/2/a5/%0d", bus.done, bus.generation, bus.best, bus.best_fit, TFIT);
        end
        $display("target_stop: done=%b generation=%0d best=%h best_fit=%0d", bus.done, bus.generation, bus.best, bus.best_fit);
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        while (t < 16) begin
            drive_fit(1'b1);
            tick();
        end
        drive_fit(1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (ctrl_vec() !== exp_vec(t) || bus.generation !== GEN_W'(exp_gen(t)) || t != 17) begin
            errors++;
            $display("FAIL start_ignored t=%0d got %b gen=%0d want %b gen=%0d", t, ctrl_vec(), bus.generation, exp_vec(t), exp_gen(t));
        end
        checks++;
        if (bus.best_fit !== m_best_fit) begin
            errors++;
            $display("FAIL start_ignored_best got %0d want %0d", bus.best_fit, m_best_fit);
        end
        do_reset();
        checks++;
        if (ctrl_vec() !== 7'b0 || {bus.src_sel, bus.sel_slot} !== 2'b00) begin
            errors++;
            $display("FAIL abort_ctrl got %b src/slot=%b want 0000000/00", ctrl_vec(), {bus.src_sel, bus.sel_slot});
        end
        checks++;
        if (bus.generation !== GEN_W'(0) || bus.best !== CHROM_W'(0) || bus.best_fit !== FIT_MIN) begin
            errors++;
            $display("FAIL abort_state got gen=%0d best=%h/%0d want 0/00/%0d", bus.generation, bus.best, bus.best_fit, FIT_MIN);
        end
        $display("reset_mid_run: busy=%b generation=%0d", bus.busy, bus.generation);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        set_fit(1'b0, 0, 0, 0, 0);
        test_reset();
        test_best();
        test_schedule();
        test_back_to_back();
        test_target_stop();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
